// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU op codes, sequencer state encoding and
// the instruction classes the decoder hands to the sequencer.
package cpu_pkg;

  localparam int OP_W    = 5;
  localparam int ALUOP_W = 4;
  localparam int ST_W    = 4;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11001;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;

  localparam logic [ST_W-1:0] S_RST  = 4'd0;
  localparam logic [ST_W-1:0] S_T0   = 4'd1;
  localparam logic [ST_W-1:0] S_T1   = 4'd2;
  localparam logic [ST_W-1:0] S_T1W  = 4'd3;
  localparam logic [ST_W-1:0] S_T2   = 4'd4;
  localparam logic [ST_W-1:0] S_T3   = 4'd5;
  localparam logic [ST_W-1:0] S_T4   = 4'd6;
  localparam logic [ST_W-1:0] S_T5   = 4'd7;
  localparam logic [ST_W-1:0] S_T6   = 4'd8;
  localparam logic [ST_W-1:0] S_T7   = 4'd9;
  localparam logic [ST_W-1:0] S_HALT = 4'd10;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_ADDI,
    CLS_LDI,
    CLS_LD,
    CLS_ST,
    CLS_NOP,
    CLS_HALT
  } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: execute-phase class, ALU op for register
// ALU instructions, and an illegal flag (illegal opcodes behave as nop).
module op_class_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  output op_class_t          op_class,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
);

  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    case (op)
      OP_ADD:  op_class = CLS_ALU;
      OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
      OP_ADDI: op_class = CLS_ADDI;
      OP_LDI:  op_class = CLS_LDI;
      OP_LD:   op_class = CLS_LD;
      OP_ST:   op_class = CLS_ST;
      OP_NOP:  op_class = CLS_NOP;
      OP_HALT: op_class = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 16-register bus datapath.
// Strobes are decoded from the T-step register and ir; state is exported for debug.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic [31:0]        ir,
  input  logic               mem_ready,
  input  logic               stop,
  output logic               PCout,
  output logic               MARin,
  output logic               IncPC,
  output logic               PCin,
  output logic               Zin,
  output logic               Zlowout,
  output logic               Yin,
  output logic               MDRout,
  output logic               MDRin,
  output logic               IRin,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               BAout,
  output logic               Cout,
  output logic               Read,
  output logic               Write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               run,
  output logic               illegal_op,
  output logic [ST_W-1:0]    state
);

  logic [ST_W-1:0]    state_q;
  logic [ST_W-1:0]    state_d;
  op_class_t          op_class;
  logic [ALUOP_W-1:0] cls_alu_op;
  logic               cls_illegal;
  logic               is_st;
  logic               is_mem;
  logic               unused_ir;

  // Register fields are selected in the datapath; only the opcode matters here.
  assign unused_ir = ^ir[26:0];

  op_class_decode u_decode (
    .op       (ir[31:27]),
    .op_class (op_class),
    .alu_op   (cls_alu_op),
    .illegal  (cls_illegal)
  );

  assign is_st  = (op_class == CLS_ST);
  assign is_mem = (op_class == CLS_LD) || is_st;
  assign state  = state_q;

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:        state_d = S_T0;
      S_T0:         state_d = stop ? S_HALT : S_T1;
      S_T1, S_T1W:  state_d = mem_ready ? S_T2 : S_T1W;
      S_T2:         state_d = S_T3;
      S_T3: begin
        case (op_class)
          CLS_NOP:  state_d = S_T0;
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_T4;
        endcase
      end
      S_T4:         state_d = S_T5;
      S_T5:         state_d = is_mem ? S_T6 : S_T0;
      S_T6:         state_d = (is_st || mem_ready) ? S_T7 : S_T6;
      S_T7:         state_d = (is_st && !mem_ready) ? S_T7 : S_T0;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_RST;
    endcase
  end

  // MDRin in the read-wait steps follows mem_ready so MDR captures exactly once.
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Yin        = 1'b0;
    MDRout     = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    alu_op     = ALU_ADD;
    run        = 1'b1;
    illegal_op = 1'b0;
    case (state_q)
      // A pending stop suppresses the fetch so the PC is left untouched.
      S_T0: begin
        if (!stop) begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_ready;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CLS_ALU, CLS_ADDI: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          default: illegal_op = cls_illegal;
        endcase
      end
      S_T4: begin
        Zin = 1'b1;
        if (op_class == CLS_ALU) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          alu_op = cls_alu_op;
        end else begin
          Cout = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_mem) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        if (is_st) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end else begin
          Read  = 1'b1;
          MDRin = mem_ready;
        end
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end
      end
      default: run = 1'b0;
    endcase
  end

  // RST, HALT and some T-steps drive nothing, so the bus rule is "at most one".
  a_one_bus_driver: assert property (@(posedge clock)
    $onehot0({PCout, Zlowout, MDRout, Rout, BAout, Cout}));

  a_alu_idle: assert property (@(posedge clock) !Zin |-> (alu_op == ALU_ADD));

endmodule
